// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data load/store.
// Optional stall/transfer counters are compiled in with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [XLEN/8-1:0] d_be_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [XLEN-1:0]   d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall_o,
    output logic [31:0]       perf_d_stall_o,
    output logic [31:0]       perf_xfer_o
`endif
);

    localparam int BEW = XLEN / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BEW-1:0]  mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic gnt_ok;
    logic rsp_ok;
    logic arb_point;
    logic pick_d;

    assign gnt_ok    = (state_q == REQ) && mem_gnt_i;
    assign rsp_ok    = (state_q == WAIT) && mem_rvalid_i;
    assign arb_point = (state_q == IDLE) || rsp_ok;
    // D wins ties unless IF has already been passed over STARVE_LIMIT times in a row.
    assign pick_d    = d_req_i && !(if_req_i && (starve_cnt_q == LIMIT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A response cycle doubles as an arbitration point so back-to-back requests skip IDLE.
        if (arb_point) begin
            if (if_req_i || d_req_i) begin
                state_d   = REQ;
                mem_req_d = 1'b1;
                if (pick_d) begin
                    owner_d     = OWN_D;
                    mem_we_d    = d_we_i;
                    mem_be_d    = d_be_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    if (!if_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else begin
                    owner_d      = OWN_IF;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = if_addr_i;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign if_gnt_o    = gnt_ok && (owner_q == OWN_IF);
    assign d_gnt_o     = gnt_ok && (owner_q == OWN_D);
    assign if_rvalid_o = rsp_ok && (owner_q == OWN_IF);
    assign d_rvalid_o  = rsp_ok && (owner_q == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_d_stall_q, perf_d_stall_d;
    logic [31:0] perf_xfer_q, perf_xfer_d;

    // A requester is stalled whenever it asks but is not the one currently presented in REQ.
    always_comb begin
        perf_if_stall_d = perf_if_stall_q;
        perf_d_stall_d  = perf_d_stall_q;
        perf_xfer_d     = perf_xfer_q;
        if (if_req_i && !((state_q == REQ) && (owner_q == OWN_IF))) begin
            perf_if_stall_d = perf_if_stall_q + 32'd1;
        end
        if (d_req_i && !((state_q == REQ) && (owner_q == OWN_D))) begin
            perf_d_stall_d = perf_d_stall_q + 32'd1;
        end
        if (gnt_ok) begin
            perf_xfer_d = perf_xfer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_if_stall_q <= '0;
            perf_d_stall_q  <= '0;
            perf_xfer_q     <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_d_stall_q  <= perf_d_stall_d;
            perf_xfer_q     <= perf_xfer_d;
        end
    end

    assign perf_if_stall_o = perf_if_stall_q;
    assign perf_d_stall_o  = perf_d_stall_q;
    assign perf_xfer_o     = perf_xfer_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level arbitration model predicts
// each memory transfer, a negedge monitor checks every grant and response against it.
module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [3:0]  d_be_i = '0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_o, perf_d_stall_o, perf_xfer_o;
`endif

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_be_i       (d_be_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall_o (perf_if_stall_o),
        .perf_d_stall_o  (perf_d_stall_o),
        .perf_xfer_o     (perf_xfer_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    txn_t exp_q[$];
    bit   resp_q[$];
    bit   gnt_log[$];
    txn_t mon_t;
    bit   mon_owner;

    bit   if_gnt_seen, d_gnt_seen, xfer_seen;
    int   if_gnt_cyc = -1, d_gnt_cyc = -1, if_rv_cyc = -1, d_rv_cyc = -1;
    int   n_xfer = 0;

    bit          mem_out;
    int          mem_cnt;
    int          mem_delay_fixed = -1;
    int          gnt_pct = 100;
    bit          use_fixed_rdata;
    logic [31:0] fixed_rdata;

    bit m_busy;
    int m_starve;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: condition not met within bound (cycle %0d)", name, cyc);
    endtask

    // Monitor: every accepted transfer must match the oldest predicted transaction,
    // and every response must reach exactly the owner of the oldest granted transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_req_o && mem_gnt_i) begin
                if (exp_q.size() == 0) begin
                    report_fail("unexpected_xfer");
                end else begin
                    mon_t = exp_q.pop_front();
                    check_output("xfer_addr", mem_addr_o, mon_t.addr);
                    check_output("xfer_we", 32'(mem_we_o), 32'(mon_t.we));
                    check_output("xfer_be", 32'(mem_be_o), 32'(mon_t.be));
                    check_output("xfer_wdata", mem_wdata_o, mon_t.wdata);
                    check_output("xfer_gnt", 32'({if_gnt_o, d_gnt_o}), mon_t.is_d ? 32'd1 : 32'd2);
                    resp_q.push_back(mon_t.is_d);
                    gnt_log.push_back(mon_t.is_d);
                    xfer_seen = 1'b1;
                    n_xfer++;
                end
            end else begin
                check_output("no_gnt", 32'({if_gnt_o, d_gnt_o}), 32'd0);
            end
            if (if_gnt_o) begin
                if_gnt_seen = 1'b1;
                if_gnt_cyc  = cyc;
            end
            if (d_gnt_o) begin
                d_gnt_seen = 1'b1;
                d_gnt_cyc  = cyc;
            end
            if (mem_rvalid_i && resp_q.size() != 0) begin
                mon_owner = resp_q.pop_front();
                check_output("rsp_valid", 32'({if_rvalid_o, d_rvalid_o}), mon_owner ? 32'd1 : 32'd2);
                check_output("rsp_rdata", mon_owner ? d_rdata_o : if_rdata_o, mem_rdata_i);
                check_output("rsp_other_rdata", mon_owner ? if_rdata_o : d_rdata_o, 32'd0);
            end else begin
                check_output("no_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
                check_output("no_rdata", if_rdata_o | d_rdata_o, 32'd0);
            end
            if (if_rvalid_o) if_rv_cyc = cyc;
            if (d_rvalid_o) d_rv_cyc = cyc;
        end
    end

    // Start of a cycle: retire granted requests and drive the memory side.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (if_gnt_seen) begin
            if_req_i    = 1'b0;
            if_gnt_seen = 1'b0;
        end
        if (d_gnt_seen) begin
            d_req_i    = 1'b0;
            d_gnt_seen = 1'b0;
        end
        mem_rvalid_i = 1'b0;
        if (xfer_seen) begin
            xfer_seen = 1'b0;
            mem_out   = 1'b1;
            mem_cnt   = (mem_delay_fixed >= 0) ? mem_delay_fixed : int'($urandom_range(0, 3));
        end
        if (mem_out) begin
            if (mem_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = use_fixed_rdata ? fixed_rdata : $urandom;
                mem_out      = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        mem_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    endtask

    // Reference model: the port is free when nothing is outstanding or a response lands now;
    // whenever it is free and someone asks, one transaction is chosen by the priority rules.
    task automatic end_cycle();
        txn_t t;
        bit   pick_d;
        if (m_busy && mem_rvalid_i) m_busy = 1'b0;
        if (!m_busy) begin
            if (if_req_i || d_req_i) begin
                pick_d  = d_req_i && !(if_req_i && m_starve == LIMIT);
                t.is_d  = pick_d;
                t.we    = pick_d ? d_we_i : 1'b0;
                t.be    = pick_d ? d_be_i : 4'hF;
                t.addr  = pick_d ? d_addr_i : if_addr_i;
                t.wdata = pick_d ? d_wdata_i : 32'd0;
                exp_q.push_back(t);
                if (pick_d && if_req_i) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
                else m_starve = 0;
                m_busy = 1'b1;
            end else begin
                m_starve = 0;
            end
        end
    endtask

    task automatic apply_stimulus(input int n, input int req_pct);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            if (!if_req_i && int'($urandom_range(0, 99)) < req_pct) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req_i && int'($urandom_range(0, 99)) < req_pct) begin
                d_req_i   = 1'b1;
                d_we_i    = 1'($urandom_range(0, 1));
                d_be_i    = 4'($urandom_range(1, 15));
                d_addr_i  = $urandom;
                d_wdata_i = $urandom;
            end
            end_cycle();
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || resp_q.size() != 0 || m_busy || if_req_i || d_req_i) && k < 300) begin
            gnt_pct = 100;
            begin_cycle();
            end_cycle();
            k++;
        end
        if (k >= 300) report_fail("drain_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        exp_q.delete(); resp_q.delete(); gnt_log.delete();
        if_gnt_seen = 1'b0; d_gnt_seen = 1'b0; xfer_seen = 1'b0;
        mem_out = 1'b0; m_busy = 1'b0; m_starve = 0; n_xfer = 0;
        #1;
        check_output("rst_mem_req", 32'({mem_req_o, mem_we_o}), 32'd0);
        check_output("rst_mem_fields", mem_addr_o | mem_wdata_o | 32'(mem_be_o), 32'd0);
        check_output("rst_gnt_rvalid", 32'({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}), 32'd0);
        check_output("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
`ifdef MEM_ARB_PERF_EN
        check_output("rst_perf", perf_if_stall_o | perf_d_stall_o | perf_xfer_o, 32'd0);
`endif
        @(posedge clk);
        #3;
        rstn = 1'b1;
    endtask

    initial begin
        int req_cyc;
        int k;

        do_reset();

        // Fetch only, response two cycles after the grant.
        gnt_pct = 100; mem_delay_fixed = 1; use_fixed_rdata = 1'b1; fixed_rdata = 32'h0000_0513;
        if_gnt_cyc = -1; if_rv_cyc = -1;
        begin_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h8000_0000; req_cyc = cyc;
        end_cycle();
        begin_cycle();
        check_output("fetch_mem_req", 32'(mem_req_o), 32'd1);
        check_output("fetch_mem_addr", mem_addr_o, 32'h8000_0000);
        check_output("fetch_mem_we", 32'(mem_we_o), 32'd0);
        end_cycle();
        k = 0;
        while (if_rv_cyc < 0 && k < 20) begin begin_cycle(); end_cycle(); k++; end
        if (if_rv_cyc < 0) report_fail("fetch_rvalid_timeout");
        check_output("fetch_gnt_cycle", 32'(if_gnt_cyc), 32'(req_cyc + 1));
        check_output("fetch_rv_cycle", 32'(if_rv_cyc), 32'(if_gnt_cyc + 2));
        drain();

        // Store held under three cycles of backpressure.
        gnt_pct = 0; d_gnt_cyc = -1;
        begin_cycle();
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
        d_addr_i = 32'h8000_1000; d_wdata_i = 32'hDEAD_BEEF; req_cyc = cyc;
        end_cycle();
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            check_output("bp_req_held", 32'({mem_req_o, mem_we_o}), 32'd3);
            check_output("bp_addr", mem_addr_o, 32'h8000_1000);
            check_output("bp_be", 32'(mem_be_o), 32'h3);
            check_output("bp_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            end_cycle();
        end
        gnt_pct = 100;
        begin_cycle(); end_cycle();
        begin_cycle();
        check_output("bp_gnt_cycle", 32'(d_gnt_cyc), 32'(req_cyc + 4));
        end_cycle();
        drain();

        // Simultaneous requests: D first, IF immediately after the D response.
        mem_delay_fixed = 0; use_fixed_rdata = 1'b0; d_rv_cyc = -1; if_gnt_cyc = -1;
        gnt_log.delete();
        begin_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h8000_2000; d_wdata_i = 32'h0;
        end_cycle();
        begin_cycle();
        check_output("sim_first_addr", mem_addr_o, 32'h8000_2000);
        end_cycle();
        drain();
        if (gnt_log.size() >= 2) check_output("sim_first_owner_d", 32'(gnt_log[0]), 32'd1);
        else report_fail("sim_grants");
        check_output("sim_if_back_to_back", 32'(if_gnt_cyc), 32'(d_rv_cyc + 1));

        // Starvation: both requesting continuously from reset.
        do_reset();
        gnt_pct = 100; mem_delay_fixed = 0;
        k = 0;
        while (gnt_log.size() < 10 && k < 200) begin apply_stimulus(1, 100); k++; end
        if (gnt_log.size() < 10) report_fail("starve_timeout");
        else begin
            for (int i = 0; i < 10; i++) begin
                check_output($sformatf("starve_order_%0d", i), 32'(gnt_log[i]), ((i % 5) != 4) ? 32'd1 : 32'd0);
            end
        end
        drain();

        // Randomized traffic against the reference model.
        mem_delay_fixed = -1;
        gnt_pct = 60;
        apply_stimulus(3000, 40);
        gnt_pct = 90;
        apply_stimulus(2000, 85);
        drain();
`ifdef MEM_ARB_PERF_EN
        check_output("perf_xfer", perf_xfer_o, 32'(n_xfer));
`endif

        // Reset while waiting for a response, then a stale response.
        mem_delay_fixed = 6; gnt_pct = 100; d_gnt_cyc = -1;
        begin_cycle();
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h8000_3000;
        end_cycle();
        k = 0;
        while (d_gnt_cyc < 0 && k < 20) begin begin_cycle(); end_cycle(); k++; end
        if (d_gnt_cyc < 0) report_fail("wait_gnt_timeout");
        do_reset();
        begin_cycle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        end_cycle();
        #2;
        check_output("stale_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
        check_output("stale_rdata", if_rdata_o | d_rdata_o, 32'd0);
        drain();
        check_output("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between core_model's fetch/LSU logic and the memory model.
- Allows one outstanding transaction. D has priority; a starvation counter bounds IF wait.
- Requests are latched, so `mem_*` request outputs are registered and stable while awaiting grant.

Parameters:
- XLEN, 32, data/address width (matches riscv_pkg::XLEN)
- STARVE_LIMIT, 4, max consecutive D selections while IF is waiting before IF is forced; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  XLEN  fetched instruction
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_be_i  in  XLEN/8  byte enables
- d_addr_i  in  XLEN  data address
- d_wdata_i  in  XLEN  store data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response valid (loads and stores)
- d_rdata_o  out  XLEN  load data
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_we_o  out  1  memory write
- mem_be_o  out  XLEN/8  memory byte enables
- mem_addr_o  out  XLEN  memory address
- mem_wdata_o  out  XLEN  memory write data
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  memory response valid; exactly one per granted request, stores included
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- **Reset (rstn=0, asynchronous):**
  - state=IDLE, owner=IF, starve_cnt=0.
  - mem_req_o/mem_we_o=0; mem_be_o/mem_addr_o/mem_wdata_o=0.
  - All gnt/rvalid outputs 0. if_rdata_o and d_rdata_o are 0 whenever their rvalid is 0.
- **FSM IDLE:**
  - Arbitration point: if either req is high, pick a winner and latch its we/be/addr/wdata into the mem_* registers and owner. Go to REQ; mem_req_o=1 from the next cycle.
  - If neither req is high, stay in IDLE.
- **FSM REQ:**
  - Hold mem_req_o and all latched fields stable.
  - On mem_gnt_i=1: owner gnt output = 1 in the same cycle (combinational); mem_req_o deasserts at the next edge; go to WAIT.
- **FSM WAIT:**
  - On mem_rvalid_i=1: owner rvalid output = 1 and owner rdata = mem_rdata_i, same cycle (combinational).
  - On that same edge, arbitrate again: a pending request goes directly to REQ (back-to-back, no IDLE bubble); otherwise go to IDLE.
- **Winner rule:**
  - Only D requesting → D. Only IF requesting → IF.
  - Both requesting → D, unless starve_cnt==STARVE_LIMIT, then IF.
- **starve_cnt:**
  - +1 when D is selected while if_req_i=1, saturating at STARVE_LIMIT.
  - Cleared when IF is selected, or when if_req_i=0 at an arbitration point.
- **Timing:**
  - Best-case request latency: req at edge N → mem_req_o at N+1 → gnt at N+1 if mem_gnt_i=1.
  - Response latency is 0 cycles from mem_rvalid_i.
- **Boundary cases:**
  - Requester dropping req before gnt is illegal; the latched transaction still completes and the response is still delivered.
  - mem_rvalid_i in IDLE or REQ (stale, e.g. after reset mid-WAIT) is ignored: no rvalid output is generated.
  - mem_gnt_i outside REQ is ignored.
  - Non-owner gnt/rvalid outputs are always 0; both gnt (or both rvalid) outputs are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- **Defined:** adds outputs perf_if_stall_o[31:0] and perf_d_stall_o[31:0].
  - Each counts cycles in which its req_i=1 and it is neither owner-in-REQ nor receiving gnt.
  - Adds perf_xfer_o[31:0], counting mem_gnt_i pulses accepted in REQ.
  - All counters wrap at 2^32 and reset to 0 on rstn.
- **Undefined:** these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- **Fetch only:** if_req_i=1, if_addr_i=0x80000000, mem_gnt_i=1 always, mem_rvalid_i 2 cycles after gnt with rdata 0x00000513 → mem_req_o next cycle with addr 0x80000000 and we=0; if_gnt_o 1 pulse; if_rvalid_o pulse with if_rdata_o=0x00000513; d_gnt_o and d_rvalid_o stay 0.
- **Simultaneous:** if_req_i and d_req_i (d_addr_i=0x80002000, load) asserted in the same IDLE cycle → first mem_addr_o=0x80002000, d_gnt_o pulses; IF is granted right after the D response, with no IDLE cycle between.
- **Starvation, STARVE_LIMIT=4:** D and IF requesting continuously → grant order D,D,D,D,IF,D…; starve_cnt returns to 0 after the IF grant.
- **Store:** d_we_i=1, d_be_i=4'b0011, addr 0x80001000, wdata 0xDEADBEEF → mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF; d_rvalid_o pulses on mem_rvalid_i.
- **Backpressure:** mem_gnt_i=0 for 3 cycles in REQ → mem_req_o held with unchanged addr/wdata/be; no gnt pulses; gnt on the 4th cycle when mem_gnt_i=1.
- **Reset mid-WAIT:** pull rstn low in WAIT, release, then drive a stale mem_rvalid_i=1 → all outputs 0 immediately on reset; the stale rvalid produces no if_rvalid_o or d_rvalid_o; with MEM_ARB_PERF_EN, counters read 0.
